// File: rtl/seq_gen_pkg.sv
// Shared types and sizing for the serial sequence generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding and default widths. LEN_W is derived so that
// the length field can hold the value PAT_W itself, not just PAT_W-1.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int PAT_W_DEF = 16;
  localparam int LEN_W_DEF = $clog2(PAT_W_DEF) + 1;
  localparam int RPT_W_DEF = 8;

endpackage

// File: rtl/seq_gen_idx_cnt.sv
// Bit-index down-counter plus period counter for the sequence generator.
// Latency: state updates one cycle after load_i/step_i.
// Backpressure: advances only on step_i (a consumed bit); holds otherwise.
//
// Ports: load_i restarts at idx=len-1/period 0; step_i consumes one bit;
// idx_o is the index of the bit currently presented; wrap_o flags idx 0;
// last_period_o flags the final period of a finite repeat count.
module seq_gen_idx_cnt #(
  parameter int LEN_W = 5,
  parameter int RPT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [RPT_W-1:0] rpt_i,
  output logic [LEN_W-1:0] idx_o,
  output logic             wrap_o,
  output logic             last_period_o
);

  logic [LEN_W-1:0] idx_q, idx_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] top_idx;

  assign top_idx = len_i - LEN_W'(1);

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (load_i) begin
      idx_d = top_idx;
      cnt_d = '0;
    end else if (step_i) begin
      if (idx_q != '0) begin
        idx_d = idx_q - LEN_W'(1);
      end else begin
        idx_d = top_idx;
        // Infinite mode never terminates on count, so keep it frozen.
        if (rpt_i != '0) cnt_d = cnt_q + RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign idx_o         = idx_q;
  assign wrap_o        = (idx_q == '0);
  assign last_period_o = (rpt_i != '0) && (cnt_q == rpt_i - RPT_W'(1));

endmodule

// File: rtl/seq_gen_ctrl.sv
// Programmable serial sequence generator: plays a shadowed pattern MSB-first.
// Latency: start -> first bit valid next cycle; last handshake -> done next cycle.
// Backpressure: valid/ready per bit; dout held stable while valid && !ready.
//
// Ports: cfg_we/cfg_pattern/cfg_len/cfg_repeat load the shadow config (IDLE
// only), cfg_err is sticky on bad length or config while busy; start/stop
// control playback; dout/dout_valid/dout_ready is the bit stream; busy and
// done report progress. All outputs are registered.
module seq_gen_ctrl
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = $clog2(PAT_W) + 1,
  parameter int RPT_W = RPT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [RPT_W-1:0] cfg_repeat,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             done
);

  localparam logic [LEN_W-1:0] PAT_LEN_MAX = LEN_W'(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             err_q, err_d;
  logic             dout_q, dout_d;
  logic             vld_q, busy_q, done_q;

  logic             load, step, hs, cfg_len_ok;
  logic [LEN_W-1:0] idx, top_idx, nxt_idx;
  logic             wrap, last_period;
  logic [PAT_W-1:0] sh_top, sh_nxt;

  seq_gen_idx_cnt #(
    .LEN_W(LEN_W),
    .RPT_W(RPT_W)
  ) u_idx_cnt (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .step_i       (step),
    .len_i        (len_q),
    .rpt_i        (rpt_q),
    .idx_o        (idx),
    .wrap_o       (wrap),
    .last_period_o(last_period)
  );

  assign hs         = vld_q && dout_ready;
  assign cfg_len_ok = (cfg_len != '0) && (cfg_len <= PAT_LEN_MAX);
  assign top_idx    = len_q - LEN_W'(1);
  // Index of the bit presented after the current one is consumed.
  assign nxt_idx    = wrap ? top_idx : (idx - LEN_W'(1));
  // Shift rather than index so a LEN_W-wide select needs no truncation.
  assign sh_top     = pat_q >> top_idx;
  assign sh_nxt     = pat_q >> nxt_idx;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    rpt_d   = rpt_q;
    err_d   = err_q;
    dout_d  = dout_q;
    load    = 1'b0;
    step    = 1'b0;

    if (cfg_we) begin
      if (state_q == IDLE && cfg_len_ok) begin
        pat_d = cfg_pattern;
        len_d = cfg_len;
        rpt_d = cfg_repeat;
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start && !stop && len_q != '0) begin
          state_d = RUN;
          load    = 1'b1;
          dout_d  = sh_top[0];
        end
      end
      RUN: begin
        // A handshake coincident with stop is still a consumed bit.
        step = hs;
        if (stop || (hs && wrap && last_period)) begin
          state_d = DONE;
        end else if (hs) begin
          dout_d = sh_nxt[0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rpt_q   <= '0;
      err_q   <= 1'b0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rpt_q   <= rpt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      vld_q   <= (state_d == RUN);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign cfg_err    = err_q;
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign done       = done_q;

endmodule
